// File: rtl/avg_pkg.sv
// avg_pkg: shared defaults and FSM encoding for sample_avg_filter.
package avg_pkg;
  localparam int DEF_DATA_W = 10;
  localparam int DEF_LOG2_TAPS = 4;
  localparam int MIDSCALE = 512;
  typedef enum logic [1:0] {IDLE, READ, UPDATE, OUTPUT} state_t;
endpackage

// File: rtl/sample_ram.sv
// sample_ram: single-port N x DATA_W sample store, one-cycle synchronous read.
module sample_ram #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [1<<ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= d;
    q <= mem[addr];
  end
endmodule

// File: rtl/sample_avg_filter.sv
// sample_avg_filter: 2^LOG2_TAPS moving average over strobed samples.
// Define AVG_DC_REMOVE_EN to output the midscale-centred DC-removed sample instead.
module sample_avg_filter
  import avg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LOG2_TAPS = DEF_LOG2_TAPS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              x_valid,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  output logic              busy
);
  localparam int N = 1 << LOG2_TAPS;
  localparam int SUM_W = DATA_W + LOG2_TAPS;
  state_t                 state;
  logic [LOG2_TAPS-1:0]   wr_ptr;
  logic [LOG2_TAPS:0]     fill;
  logic [SUM_W-1:0]       sum, sum_nxt;
  logic [DATA_W-1:0]      x_reg, ram_q, old, avg_nxt, y_nxt;
  logic                   full;
  sample_ram #(.DATA_W(DATA_W), .ADDR_W(LOG2_TAPS)) u_ram (
    .clk(clk), .we(state == UPDATE), .addr(wr_ptr), .d(x_reg), .q(ram_q)
  );
  // The RAM reads wr_ptr every cycle, so ram_q holds the oldest tap by UPDATE.
  always_comb begin
    full = fill == (LOG2_TAPS+1)'(N);
    old = full ? ram_q : '0;
    sum_nxt = sum + SUM_W'(x_reg) - SUM_W'(old);
    avg_nxt = DATA_W'(sum_nxt >> LOG2_TAPS);
  end
`ifdef AVG_DC_REMOVE_EN
  localparam logic signed [DATA_W+1:0] MID = (DATA_W+2)'(MIDSCALE);
  localparam logic signed [DATA_W+1:0] TOP = (DATA_W+2)'((1 << DATA_W) - 1);
  logic signed [DATA_W+1:0] hp;
  always_comb begin
    hp = $signed({2'b00, x_reg}) - $signed({2'b00, avg_nxt}) + MID;
    y_nxt = hp < 0 ? '0 : hp > TOP ? '1 : hp[DATA_W-1:0];
  end
`else
  assign y_nxt = avg_nxt;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      fill <= '0;
      sum <= '0;
      x_reg <= '0;
      y <= '0;
      y_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (x_valid) begin
          x_reg <= x;
          busy <= 1'b1;
          state <= READ;
        end
        READ: state <= UPDATE;
        UPDATE: begin
          sum <= sum_nxt;
          wr_ptr <= wr_ptr + 1'b1;
          if (!full) fill <= fill + 1'b1;
          y <= y_nxt;
          y_valid <= 1'b1;
          state <= OUTPUT;
        end
        default: begin
          y_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sample_avg_filter.sv
// tb_sample_avg_filter: directed vector bench for sample_avg_filter.
// With AVG_DC_REMOVE_EN defined it checks the DC-removal output instead.
module tb_sample_avg_filter;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       x_valid = 0;
  logic [9:0] x = 0;
  logic [9:0] y;
  logic       y_valid, busy;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
  } vec_t;

  sample_avg_filter dut (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x(x),
    .y(y), .y_valid(y_valid), .busy(busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    x_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // Strobe one sample and check the full 4-cycle handshake.
  task automatic apply(input logic [9:0] v, input logic [9:0] exp, input string n);
    x = v;
    x_valid = 1;
    @(negedge clk);
    x_valid = 0;
    chk({n, " busy t+1"}, busy, 1);
    chk({n, " y_valid t+1"}, y_valid, 0);
    @(negedge clk);
    chk({n, " y_valid t+2"}, y_valid, 0);
    @(negedge clk);
    chk({n, " y_valid t+3"}, y_valid, 1);
    chk({n, " busy t+3"}, busy, 1);
    chk({n, " y"}, y, exp);
    @(negedge clk);
    chk({n, " y_valid t+4"}, y_valid, 0);
    chk({n, " busy t+4"}, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    int e;
    // Reset held: strobes must be ignored.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      x = 10'd1023;
      x_valid = i[0];
      chk("reset y", y, 0);
      chk("reset y_valid", y_valid, 0);
      chk("reset busy", busy, 0);
    end
    x_valid = 0;
    rst_n = 1;
    @(negedge clk);
`ifdef AVG_DC_REMOVE_EN
    for (int k = 1; k <= 16; k++) begin
      e = 700 - (700 * k) / 16 + 512;
      v.x = 10'd700;
      v.y = e > 1023 ? 10'd1023 : 10'(e);
      vecs.push_back(v);
    end
    v.x = 10'd0;
    v.y = 10'd0;
    vecs.push_back(v);
    foreach (vecs[i]) apply(vecs[i].x, vecs[i].y, $sformatf("dc[%0d]", i));
    chk("dc first", vecs[0].y, 1023);
    chk("dc settled", vecs[15].y, 512);
`else
    apply(10'd160, 10'd10, "latency");

    // Drop while busy: extra strobes at t+1 and t+3 are ignored.
    do_reset();
    x = 10'd1000;
    x_valid = 1;
    @(negedge clk);
    x = 10'd0;
    chk("drop busy t+1", busy, 1);
    @(negedge clk);
    x_valid = 0;
    chk("drop y_valid t+2", y_valid, 0);
    @(negedge clk);
    x_valid = 1;
    chk("drop y_valid t+3", y_valid, 1);
    chk("drop y", y, 62);
    @(negedge clk);
    x_valid = 0;
    chk("drop y_valid t+4", y_valid, 0);
    chk("drop busy t+4", busy, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("drop no extra y_valid", y_valid, 0);
    end
    apply(10'd0, 10'd62, "drop sum kept");

    // Warm-up step up then down.
    do_reset();
    vecs.delete();
    for (int i = 0; i < 16; i++) begin
      v.x = 10'd512;
      v.y = 10'(32 * (i + 1));
      vecs.push_back(v);
    end
    for (int i = 0; i < 16; i++) begin
      v.x = 10'd0;
      v.y = 10'(512 - 32 * (i + 1));
      vecs.push_back(v);
    end
    foreach (vecs[i]) apply(vecs[i].x, vecs[i].y, $sformatf("step[%0d]", i));

    // Ramp through several pointer wraps.
    do_reset();
    vecs.delete();
    for (int k = 0; k < 40; k++) begin
      v.x = 10'(k * 16);
      v.y = k >= 15 ? 10'(8 * (2 * k - 15)) : 10'(k * (k + 1) / 2);
      vecs.push_back(v);
    end
    foreach (vecs[i]) apply(vecs[i].x, vecs[i].y, $sformatf("wrap[%0d]", i));

    // Reset mid-sample aborts it; warm-up restarts from empty.
    @(negedge clk);
    x = 10'd800;
    x_valid = 1;
    @(negedge clk);
    x_valid = 0;
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort y_valid", y_valid, 0);
      chk("abort busy", busy, 0);
      chk("abort y", y, 0);
    end
    rst_n = 1;
    @(negedge clk);
    apply(10'd160, 10'd10, "after abort");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
